// File: rtl/stream_loop_kernel_pkg.sv
// Shared types and default widths for the streaming loop kernel.
package loop_kernel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } kstate_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_OFFSET      = 2;
    localparam int DEF_PIPE_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/stream_loop_kernel_if.sv
// FIFO-side bus of the loop kernel: upstream pop port and downstream push port.
interface stream_loop_kernel_if
    import loop_kernel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] arg_0_out_data;
    logic             arg_0_read_valid;
    logic             arg_0_read_ready;
    logic [WIDTH-1:0] fifo_1_in_data;
    logic             fifo_1_write_valid;
    logic             fifo_1_write_ready;

    modport master (
        input  arg_0_out_data,
        input  arg_0_read_ready,
        output arg_0_read_valid,
        output fifo_1_in_data,
        output fifo_1_write_valid,
        input  fifo_1_write_ready
    );

    modport slave (
        output arg_0_out_data,
        output arg_0_read_ready,
        input  arg_0_read_valid,
        input  fifo_1_in_data,
        input  fifo_1_write_valid,
        output fifo_1_write_ready
    );
endinterface

// File: rtl/stream_loop_kernel_buf.sv
// Show-ahead synchronous result FIFO; a full buffer still accepts a push
// when an entry leaves in the same cycle.
module loop_result_buf
    import loop_kernel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/stream_loop_kernel.sv
// Loop kernel: pops n words, computes (OFFSET + x) + x through a register
// pipeline and pushes results in order, with credits bounding words in flight.
module stream_loop_kernel
    import loop_kernel_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int OFFSET      = DEF_OFFSET,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int BUF_DEPTH   = PIPE_STAGES + 2,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_iters,
    output logic                 busy,
    output logic                 valid,
    stream_loop_kernel_if.master bus
);
    localparam int FW = $clog2(BUF_DEPTH + 1);

    kstate_t          state, state_nxt;
    logic [CNT_W-1:0] n_q, issued, written;
    logic [FW-1:0]    inflight, buf_count;
    logic             buf_empty, buf_full;
    logic [WIDTH-1:0] buf_head;
    logic             start_acc, pop, xfer, push_buf;

    logic             vld_p0;
    logic [WIDTH-1:0] x_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] res_p2 [PIPE_STAGES];
    logic             vld_p2 [PIPE_STAGES];

    function automatic logic [WIDTH-1:0] kernel_op(input logic [WIDTH-1:0] x);
        return (WIDTH'(OFFSET) + x) + x;
    endfunction

    assign start_acc = start && (state == IDLE || state == DONE);
    // Buffer-full term is implied by the credit sum; kept as a direct guard.
    assign pop = (state == RUN) && bus.arg_0_read_ready && (issued < n_q) &&
                 ((FW+1)'(inflight) + (FW+1)'(buf_count) < (FW+1)'(BUF_DEPTH)) &&
                 !buf_full;
    assign push_buf = vld_p2[PIPE_STAGES-1];
    assign xfer     = !buf_empty && bus.fifo_1_write_ready;

    assign bus.arg_0_read_valid   = pop;
    assign bus.fifo_1_write_valid = !buf_empty;
    assign bus.fifo_1_in_data     = buf_empty ? '0 : buf_head;
    assign busy  = (state == RUN) || (state == DRAIN);
    assign valid = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection for the run sequence.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = (num_iters == '0) ? DONE : RUN;
            RUN:        if (issued == n_q) state_nxt = DRAIN;
            DRAIN:      if (written == n_q) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Run length latch plus issued/written/in-flight counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            issued   <= '0;
            written  <= '0;
            inflight <= '0;
        end else begin
            if (start_acc) begin
                n_q     <= num_iters;
                issued  <= '0;
                written <= '0;
            end else begin
                if (pop)  issued  <= issued + CNT_W'(1);
                if (xfer) written <= written + CNT_W'(1);
            end
            case ({pop, push_buf})
                2'b10:   inflight <= inflight + FW'(1);
                2'b01:   inflight <= inflight - FW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Valid chain: p0 marks a pop (data on the bus now), p1 input capture, p2.. kernel stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            for (int k = 0; k < PIPE_STAGES; k++) vld_p2[k] <= 1'b0;
        end else begin
            vld_p0    <= pop;
            vld_p1    <= vld_p0;
            vld_p2[0] <= vld_p1;
            for (int k = 1; k < PIPE_STAGES; k++) vld_p2[k] <= vld_p2[k-1];
        end
    end

    // Data path registers, qualified only by the valid chain.
    always_ff @(posedge clk) begin
        x_p1      <= bus.arg_0_out_data;
        res_p2[0] <= kernel_op(x_p1);
        for (int k = 1; k < PIPE_STAGES; k++) res_p2[k] <= res_p2[k-1];
    end

    loop_result_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_buf),
        .push_data (res_p2[PIPE_STAGES-1]),
        .pop       (xfer),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );
endmodule

// File: tb/tb_stream_loop_kernel.sv
// Scoreboard bench for stream_loop_kernel: upstream FIFO model, downstream
// monitor popping expected results, and directed runs.
module tb_stream_loop_kernel;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_iters;
    logic        busy;
    logic        valid;

    stream_loop_kernel_if #(.WIDTH(32)) bus();

    stream_loop_kernel #(
        .WIDTH(32), .OFFSET(2), .PIPE_STAGES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_iters(num_iters),
        .busy(busy), .valid(valid), .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pops = 0;
    int          rv_viol = 0;
    bit          toggle_mode = 1'b0;
    bit          phase = 1'b0;
    bit          will_pop;
    logic [31:0] up_q [$];
    logic [31:0] exp_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Upstream FIFO model: pop seen before the edge, data presented after it.
    initial begin
        bus.arg_0_out_data   = '0;
        bus.arg_0_read_ready = 1'b0;
        forever begin
            @(negedge clk);
            will_pop = bus.arg_0_read_valid && bus.arg_0_read_ready;
            if (bus.arg_0_read_valid && !bus.arg_0_read_ready) rv_viol++;
            @(posedge clk);
            #1;
            if (will_pop && up_q.size() > 0) begin
                bus.arg_0_out_data = up_q.pop_front();
                pops++;
            end
            phase = ~phase;
            bus.arg_0_read_ready = (up_q.size() > 0) && (!toggle_mode || phase);
        end
    end

    // Downstream monitor: every accepted write must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.fifo_1_write_valid && bus.fifo_1_write_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %h expected no write", bus.fifo_1_in_data);
                end else begin
                    check("result", bus.fifo_1_in_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        num_iters = 16'(n);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: not complete after %0d cycles (valid=%b pending=%0d) expected done",
                     nm, budget, valid, exp_q.size());
        end
        tick(1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_busy"},  32'(busy), 32'd0);
        check({nm, "_valid"}, 32'(valid), 32'd0);
        check({nm, "_rv"},    32'(bus.arg_0_read_valid), 32'd0);
        check({nm, "_wv"},    32'(bus.fifo_1_write_valid), 32'd0);
        check({nm, "_data"},  bus.fifo_1_in_data, 32'd0);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_iters = '0;
        bus.fifo_1_write_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset");

        // Zero iterations: done immediately, no pops, never busy.
        base = pops;
        do_start(0);
        check("zero_valid", 32'(valid), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        tick(4);
        check("zero_pops", 32'(pops - base), 32'd0);

        // Basic run.
        bus.fifo_1_write_ready = 1'b1;
        up_q = '{32'd1, 32'd2, 32'd3};
        exp_q = '{32'd4, 32'd6, 32'd8};
        base = pops;
        do_start(3);
        wait_done("basic_done", 100);
        check("basic_pops", 32'(pops - base), 32'd3);
        check("basic_busy", 32'(busy), 32'd0);
        check("basic_valid", 32'(valid), 32'd1);

        // Output stall: credits allow only BUF_DEPTH pops.
        bus.fifo_1_write_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            up_q.push_back(32'(i));
            exp_q.push_back(32'(2 * i + 2));
        end
        base = pops;
        do_start(16);
        tick(30);
        check("stall_pops", 32'(pops - base), 32'd4);
        check("stall_rv", 32'(bus.arg_0_read_valid), 32'd0);
        check("stall_head", bus.fifo_1_in_data, 32'd2);
        tick(3);
        check("stall_hold", bus.fifo_1_in_data, 32'd2);
        bus.fifo_1_write_ready = 1'b1;
        wait_done("stall_done", 300);
        check("stall_total_pops", 32'(pops - base), 32'd16);

        // Input starvation: ready toggles every cycle.
        toggle_mode = 1'b1;
        up_q = '{32'd5, 32'd6, 32'd7};
        exp_q = '{32'd12, 32'd14, 32'd16};
        base = rv_viol;
        do_start(3);
        wait_done("starve_done", 100);
        check("starve_rv_without_ready", 32'(rv_viol - base), 32'd0);
        toggle_mode = 1'b0;

        // Wrap-around modulo 2^32.
        up_q = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
        exp_q = '{32'h0000_0000, 32'h0000_0000};
        do_start(2);
        wait_done("wrap_done", 100);

        // Start while busy must not change the run length.
        up_q = '{32'd1, 32'd2, 32'd3, 32'd50, 32'd51};
        exp_q = '{32'd4, 32'd6, 32'd8};
        base = pops;
        do_start(3);
        tick(1);
        num_iters = 16'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("restart_done", 100);
        check("restart_pops", 32'(pops - base), 32'd3);
        up_q.delete();
        tick(2);

        // Reset mid-run discards the run.
        bus.fifo_1_write_ready = 1'b0;
        up_q = '{32'd1, 32'd2, 32'd3};
        do_start(3);
        tick(8);
        check("midrun_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        check_idle_outputs("midrun_rst");
        rst = 1'b0;
        up_q.delete();
        tick(2);

        // A fresh run after the abort.
        bus.fifo_1_write_ready = 1'b1;
        up_q = '{32'd1, 32'd2, 32'd3};
        exp_q = '{32'd4, 32'd6, 32'd8};
        base = pops;
        do_start(3);
        wait_done("after_rst_done", 100);
        check("after_rst_pops", 32'(pops - base), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
